fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 23 ++
 rtl/fetch_ctrl_adder_32.sv | 10 +
 rtl/fetch_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding, PC defaults and address helpers.
package fetch_ctrl_pkg;

    localparam logic [31:0] PC_START_DEFAULT = 32'h00400020;
    localparam logic [31:0] PC_STEP_DEFAULT  = 32'h00000004;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        LOAD  = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction SRAM port shared between the fetch controller and the memory.
interface fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        imem_cs;
    logic        imem_we;

    modport master (
        output imem_addr,
        output imem_din,
        output imem_cs,
        output imem_we
    );

    modport slave (
        input imem_addr,
        input imem_din,
        input imem_cs,
        input imem_we
    );

endinterface

// File: rtl/fetch_ctrl_adder_32.sv
// Plain 32-bit wrap-around adder used for the sequential PC increment.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, branch redirect, stall handling
// with a one-entry pending redirect, and a program-loader path into the imem.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_START = PC_START_DEFAULT,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ack,
    output logic [31:0]       pc_out,
    output logic              fetch_valid,
    output logic              misalign_err,
    fetch_ctrl_if.master      imem
);

    fetch_state_e state, state_next;
    logic [31:0]  pc, pc_next, pc_inc;
    logic [31:0]  pend, pend_next;
    logic         pend_v, pend_v_next;
    logic         mis, mis_next;
    logic [31:0]  target;
    logic         target_mis;
    logic         writing;

    adder_32 u_pc_adder (
        .a   (pc),
        .b   (PC_STEP),
        .sum (pc_inc)
    );

    assign target     = word_align(branch_target);
    assign target_mis = (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= BOOT;
            pc     <= PC_START;
            pend   <= '0;
            pend_v <= 1'b0;
            mis    <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            pend   <= pend_next;
            pend_v <= pend_v_next;
            mis    <= mis_next;
        end
    end

    // A branch seen while stalled is parked in the pending slot; the latest wins.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        pend_next   = pend;
        pend_v_next = pend_v;
        mis_next    = mis;
        case (state)
            BOOT: state_next = RUN;
            RUN, STALL: begin
                if (load_req) begin
                    state_next = LOAD;
                end else if (stall_in) begin
                    state_next = STALL;
                    if (branch_taken) begin
                        pend_next   = target;
                        pend_v_next = 1'b1;
                        mis_next    = mis | target_mis;
                    end
                end else begin
                    state_next = RUN;
                    if (branch_taken) begin
                        pc_next  = target;
                        mis_next = mis | target_mis;
                    end else if (state == RUN) begin
                        pc_next = pc_inc;
                    end else if (pend_v) begin
                        pc_next = pend;
                    end
                    if (state == STALL) begin
                        pend_v_next = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (!load_req) begin
                    state_next = BOOT;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        writing        = (state == LOAD) && load_req;
        load_ack       = writing;
        imem.imem_we   = writing;
        imem.imem_cs   = writing || (state != BOOT);
        imem.imem_addr = writing ? load_addr : pc;
        imem.imem_din  = writing ? load_data : '0;
        fetch_valid    = (state == RUN) && !stall_in && !load_req;
        pc_out         = pc;
        misalign_err   = mis;
    end

endmodule
